mem_req_arbiter_rr: RTL and testbench

- Shares the single RAM port of the scheduler core among three requesters: icache (read-only), dcache (read/write) and the tensor-core scratchpad (read/write).
- Round-robin grant, one transaction per grant, non-preemptive.
- Bounded retry on RAM ERROR.
- Sits between the caches/scratchpad and the core's RAM interface.

---
 rtl/mem_req_arbiter_rr.sv | 113 +++++++++++
 tb/tb_mem_req_arbiter_rr.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter_rr.sv
// mem_req_arbiter_rr: round-robin arbiter sharing one RAM port among icache, dcache and scratchpad.
// Optional MEMARB_FIXED_PRIO_EN selects fixed priority dcache > icache > scratchpad.
module mem_req_arbiter_rr #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_RETRY = 3
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [DATA_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              dwait,
   output logic [DATA_W-1:0] dload,
   input  logic              sREN,
   input  logic              sWEN,
   input  logic [ADDR_W-1:0] saddr,
   input  logic [DATA_W-1:0] sstore,
   output logic              swait,
   output logic [DATA_W-1:0] sload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              err,
   output logic [1:0]        grant_id
);
   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] ERROR  = 2'd3;
   typedef enum logic [1:0] {IDLE, XFER, RETRY} state_t;
   state_t          state_q, state_d;
   logic [1:0]      owner_q, owner_d, last_q, last_d, pick;
   logic [RW-1:0]   retry_q, retry_d;
   logic [3:0]      req;
   logic            own_req, active, err_done, done, cmpl;
   assign req      = {sREN | sWEN, dREN | dWEN, iREN, 1'b0};
   assign own_req  = req[owner_q];
   assign active   = state_q == XFER && own_req;
   assign err_done = active && ramstate == ERROR && retry_q == RW'(MAX_RETRY);
   assign done     = active && (ramstate == ACCESS || err_done);
   assign cmpl     = state_q == XFER && ramstate == ACCESS;
`ifdef MEMARB_FIXED_PRIO_EN
   assign pick = req[2] ? 2'd2 : req[1] ? 2'd1 : req[3] ? 2'd3 : 2'd0;
`else
   logic [1:0] c1, c2, c3;
   assign c1   = last_q == 2'd3 ? 2'd1 : last_q + 2'd1;
   assign c2   = c1 == 2'd3 ? 2'd1 : c1 + 2'd1;
   assign c3   = c2 == 2'd3 ? 2'd1 : c2 + 2'd1;
   assign pick = req[c1] ? c1 : req[c2] ? c2 : req[c3] ? c3 : 2'd0;
`endif
   // last_q resets to icache so the rotation hands the first grant to dcache
   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= 2'd0;
         last_q  <= 2'd1;
         retry_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         retry_q <= retry_d;
      end
   end
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      retry_d = retry_q;
      case (state_q)
         IDLE: if (pick != 2'd0) begin
            state_d = XFER;
            owner_d = pick;
         end
         XFER: if (!own_req || done) begin
            state_d = IDLE;
            owner_d = 2'd0;
            last_d  = owner_q;
            retry_d = '0;
         end else if (ramstate == ERROR) begin
            state_d = RETRY;
            retry_d = retry_q + 1'b1;
         end
         RETRY: if (!own_req) begin
            state_d = IDLE;
            owner_d = 2'd0;
            last_d  = owner_q;
            retry_d = '0;
         end else state_d = XFER;
         default: state_d = IDLE;
      endcase
   end
   assign ramREN   = active && (owner_q == 2'd1 ? iREN : owner_q == 2'd2 ? dREN : sREN);
   assign ramWEN   = active && (owner_q == 2'd2 ? dWEN : owner_q == 2'd3 && sWEN);
   assign ramaddr  = !active ? '0 : owner_q == 2'd1 ? iaddr : owner_q == 2'd2 ? daddr : saddr;
   assign ramstore = (!active || owner_q == 2'd1) ? '0 : owner_q == 2'd2 ? dstore : sstore;
   assign err      = err_done;
   assign grant_id = owner_q;
   assign iwait    = req[1] && !(owner_q == 2'd1 && cmpl);
   assign dwait    = req[2] && !(owner_q == 2'd2 && cmpl);
   assign swait    = req[3] && !(owner_q == 2'd3 && cmpl);
   assign iload    = ramload;
   assign dload    = ramload;
   assign sload    = ramload;
endmodule

// File: tb/tb_mem_req_arbiter_rr.sv
// tb_mem_req_arbiter_rr: table-driven cycle vectors plus a hand-written stall sequence.
module tb_mem_req_arbiter_rr;
   localparam logic [31:0] IA = 32'h100, DA = 32'h40, SA = 32'h200;
   localparam logic [31:0] DS = 32'h12345678, SS = 32'hA5A5A5A5;
   localparam logic [1:0] F = 2'd0, B = 2'd1, A = 2'd2, E = 2'd3;
   typedef struct {
      logic rst;
      logic [2:0] ren, wen;
      logic [1:0] rs;
      logic [31:0] load;
      logic e_ren, e_wen;
      logic [31:0] e_addr, e_store;
      logic e_err;
      logic [1:0] e_gid;
      logic [2:0] e_wait, wmask;
   } vec_t;
   logic CLK = 1'b0, rst = 1'b1;
   logic iREN = 0, dREN = 0, dWEN = 0, sREN = 0, sWEN = 0;
   logic [31:0] iaddr = IA, daddr = DA, saddr = SA, dstore = DS, sstore = SS, ramload = 0;
   logic [1:0] ramstate = F;
   logic iwait, dwait, swait, ramREN, ramWEN, err;
   logic [31:0] iload, dload, sload, ramaddr, ramstore;
   logic [1:0] grant_id;
   int n_vec = 0, n_bad = 0;
   vec_t tv[$];
   always #5 CLK = ~CLK;
   mem_req_arbiter_rr dut (
      .CLK(CLK), .rst(rst),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
      .sREN(sREN), .sWEN(sWEN), .saddr(saddr), .sstore(sstore), .swait(swait), .sload(sload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .err(err), .grant_id(grant_id)
   );
   function automatic vec_t mk(logic r, logic [2:0] ren, logic [2:0] wen, logic [1:0] rs,
                               logic [31:0] load, logic er, logic ew, logic [31:0] ea,
                               logic [31:0] es, logic ee, logic [1:0] eg, logic [2:0] ewt);
      vec_t v;
      v.rst = r; v.ren = ren; v.wen = wen; v.rs = rs; v.load = load;
      v.e_ren = er; v.e_wen = ew; v.e_addr = ea; v.e_store = es; v.e_err = ee;
      v.e_gid = eg; v.e_wait = ewt; v.wmask = 3'b111;
      return v;
   endfunction
   task automatic check(string name, logic ok);
      n_vec++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got ren=%b wen=%b addr=%h store=%h err=%b gid=%0d wait(s,d,i)=%b loads=%h/%h/%h",
                  name, ramREN, ramWEN, ramaddr, ramstore, err, grant_id, {swait, dwait, iwait},
                  iload, dload, sload);
      end
   endtask
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      vec_t z;
      z = mk(0, 0, 0, F, 0, 0, 0, 0, 0, 0, 0, 0);
      tv.push_back(mk(1, 0, 0, F, 0, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(0, 3'b001, 0, F, 0, 0, 0, 0, 0, 0, 0, 3'b001));
      tv.push_back(mk(0, 3'b001, 0, B, 0, 1, 0, IA, 0, 0, 1, 3'b001));
      tv.push_back(mk(0, 3'b001, 0, A, 32'hDEADBEEF, 1, 0, IA, 0, 0, 1, 3'b000));
      tv.push_back(z);
      for (int k = 0; k < 2; k++) begin
         tv.push_back(mk(0, 3'b111, 0, A, 1 + 6 * k, 0, 0, 0, 0, 0, 0, 3'b111));
         tv.push_back(mk(0, 3'b111, 0, A, 2 + 6 * k, 1, 0, DA, DS, 0, 2, 3'b101));
         tv.push_back(mk(0, 3'b111, 0, A, 3 + 6 * k, 0, 0, 0, 0, 0, 0, 3'b111));
         tv.push_back(mk(0, 3'b111, 0, A, 4 + 6 * k, 1, 0, SA, SS, 0, 3, 3'b011));
         tv.push_back(mk(0, 3'b111, 0, A, 5 + 6 * k, 0, 0, 0, 0, 0, 0, 3'b111));
         tv.push_back(mk(0, 3'b111, 0, A, 6 + 6 * k, 1, 0, IA, 0, 0, 1, 3'b110));
      end
      tv.push_back(z);
      tv.push_back(mk(0, 0, 3'b010, F, 0, 0, 0, 0, 0, 0, 0, 3'b010));
      tv.push_back(mk(0, 0, 3'b010, B, 0, 0, 1, DA, DS, 0, 2, 3'b010));
      tv.push_back(mk(0, 0, 3'b010, B, 0, 0, 1, DA, DS, 0, 2, 3'b010));
      tv.push_back(mk(0, 0, 3'b010, A, 0, 0, 1, DA, DS, 0, 2, 3'b000));
      tv.push_back(z);
      tv.push_back(mk(0, 3'b100, 0, F, 0, 0, 0, 0, 0, 0, 0, 3'b100));
      for (int k = 0; k < 2; k++) begin
         tv.push_back(mk(0, 3'b100, 0, E, 0, 1, 0, SA, SS, 0, 3, 3'b100));
         tv.push_back(mk(0, 3'b100, 0, F, 0, 0, 0, 0, 0, 0, 3, 3'b100));
      end
      tv.push_back(mk(0, 3'b100, 0, A, 32'hCAFEF00D, 1, 0, SA, SS, 0, 3, 3'b000));
      tv.push_back(z);
      tv.push_back(mk(0, 3'b100, 0, F, 0, 0, 0, 0, 0, 0, 0, 3'b100));
      for (int k = 0; k < 3; k++) begin
         tv.push_back(mk(0, 3'b100, 0, E, 0, 1, 0, SA, SS, 0, 3, 3'b100));
         tv.push_back(mk(0, 3'b100, 0, F, 0, 0, 0, 0, 0, 0, 3, 3'b100));
      end
      tv.push_back(mk(0, 3'b100, 0, E, 0, 1, 0, SA, SS, 1, 3, 3'b100));
      tv[tv.size() - 1].wmask = 3'b011;
      tv.push_back(z);
      tv.push_back(mk(0, 3'b010, 0, F, 0, 0, 0, 0, 0, 0, 0, 3'b010));
      tv.push_back(mk(0, 3'b011, 0, B, 0, 1, 0, DA, DS, 0, 2, 3'b011));
      tv.push_back(mk(0, 3'b001, 0, B, 0, 0, 0, 0, 0, 0, 2, 3'b001));
      tv.push_back(mk(0, 3'b001, 0, F, 0, 0, 0, 0, 0, 0, 0, 3'b001));
      tv.push_back(mk(0, 3'b001, 0, A, 0, 1, 0, IA, 0, 0, 1, 3'b000));
      tv.push_back(z);
      tv.push_back(mk(0, 3'b010, 0, F, 0, 0, 0, 0, 0, 0, 0, 3'b010));
      tv.push_back(mk(0, 3'b010, 0, A, 0, 1, 0, DA, DS, 0, 2, 3'b000));
      tv.push_back(z);
      tv.push_back(mk(0, 0, 3'b100, F, 0, 0, 0, 0, 0, 0, 0, 3'b100));
      tv.push_back(mk(0, 0, 3'b100, B, 0, 0, 1, SA, SS, 0, 3, 3'b100));
      tv.push_back(mk(1, 0, 3'b100, B, 0, 0, 1, SA, SS, 0, 3, 3'b100));
      tv.push_back(mk(0, 3'b011, 3'b100, F, 0, 0, 0, 0, 0, 0, 0, 3'b111));
      tv.push_back(mk(0, 3'b011, 3'b100, A, 0, 1, 0, DA, DS, 0, 2, 3'b101));
      tv.push_back(z);
      repeat (2) cyc();
      foreach (tv[n]) begin
         vec_t v;
         v = tv[n];
         rst = v.rst; iREN = v.ren[0]; dREN = v.ren[1]; sREN = v.ren[2];
         dWEN = v.wen[1]; sWEN = v.wen[2]; ramstate = v.rs; ramload = v.load;
         #1;
         check($sformatf("vec%0d", n),
               ramREN === v.e_ren && ramWEN === v.e_wen && ramaddr === v.e_addr &&
               ramstore === v.e_store && err === v.e_err && grant_id === v.e_gid &&
               (({swait, dwait, iwait} ^ v.e_wait) & v.wmask) == 3'b000 &&
               iload === v.load && dload === v.load && sload === v.load);
         cyc();
      end
      begin
         bit seen = 0;
         iREN = 1; ramstate = B; ramload = 32'h0BADF00D;
         for (int k = 0; k < 4 && !seen; k++) begin
            #1;
            if (ramREN === 1'b1) seen = 1;
            else cyc();
         end
         check("stall_grant", seen && grant_id === 2'd1 && ramaddr === IA);
         for (int k = 0; k < 3; k++) begin
            check($sformatf("stall_hold%0d", k), iwait === 1'b1 && ramREN === 1'b1 && grant_id === 2'd1);
            cyc();
         end
         ramstate = A;
         #1;
         check("stall_done", iwait === 1'b0 && iload === 32'h0BADF00D && err === 1'b0);
         cyc();
         iREN = 0; ramstate = F;
         #1;
         check("stall_idle", grant_id === 2'd0 && ramREN === 1'b0 && iwait === 1'b0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
